// File: rtl/dmem_responder_pkg.sv
// Shared types and decode helpers for the byte-serial data-memory responder.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    RW_WORD    = 2'b00,
    RW_HALF    = 2'b01,
    RW_BYTE    = 2'b10,
    RW_ILLEGAL = 2'b11
  } rw_mode_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBeat = 2'b01,
    StResp = 2'b10
  } state_e;

  // Index of the final beat (N-1) for a given access size.
  function automatic logic [1:0] last_beat(logic [1:0] mode);
    case (mode)
      RW_WORD: last_beat = 2'd3;
      RW_HALF: last_beat = 2'd1;
      default: last_beat = 2'd0;
    endcase
  endfunction

  // Illegal size or misaligned word/half access.
  function automatic logic access_err(logic [1:0] mode, logic [1:0] addr_lsb);
    case (mode)
      RW_WORD: access_err = (addr_lsb != 2'b00);
      RW_HALF: access_err = addr_lsb[0];
      RW_BYTE: access_err = 1'b0;
      default: access_err = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_byte_ram.sv
// Single-port byte RAM: synchronous write, combinational read, contents never reset.
module dmem_responder_byte_ram #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: serialises word/half/byte accesses into one byte beat per cycle.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        wr_en_dmem,
  input  logic [1:0]  rw_mode,
  input  logic        load_unsigned,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       data_q, data_d;
  logic              wr_q, wr_d;
  logic [1:0]        mode_q, mode_d;
  logic              uns_q, uns_d;
  logic              err_q, err_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;

  logic unused_addr;
  assign unused_addr = ^req_addr[31:ADDR_W];

  // Beat address wraps naturally at the top of storage.
  assign ram_addr  = addr_q + ADDR_W'(cnt_q);
  assign ram_wdata = wdata_q[{cnt_q, 3'b000} +: 8];

  dmem_responder_byte_ram #(
    .ADDR_W(ADDR_W)
  ) u_byte_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    wr_d    = wr_q;
    mode_d  = mode_q;
    uns_d   = uns_q;
    err_d   = err_q;
    ram_we  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d  = req_addr[ADDR_W-1:0];
          wdata_d = req_wdata;
          wr_d    = wr_en_dmem;
          mode_d  = rw_mode;
          uns_d   = load_unsigned;
          cnt_d   = 2'd0;
          data_d  = '0;
          err_d   = access_err(rw_mode, req_addr[1:0]);
          // Rejected accesses skip the beats and answer in the next cycle.
          state_d = err_d ? StResp : StBeat;
        end
      end
      StBeat: begin
        ram_we = wr_q;
        if (!wr_q) begin
          data_d[{cnt_q, 3'b000} +: 8] = ram_rdata;
        end
        if (cnt_q == last_beat(mode_q)) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      mode_q  <= 2'b00;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      mode_q  <= mode_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_err   = (state_q == StResp) && err_q;

  always_comb begin
    resp_rdata = '0;
    if ((state_q == StResp) && !err_q && !wr_q) begin
      case (mode_q)
        RW_WORD: resp_rdata = data_q;
        RW_HALF: resp_rdata = uns_q ? {16'h0000, data_q[15:0]}
                                    : {{16{data_q[15]}}, data_q[15:0]};
        RW_BYTE: resp_rdata = uns_q ? {24'h000000, data_q[7:0]}
                                    : {{24{data_q[7]}}, data_q[7:0]};
        default: resp_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        wr_en_dmem;
  logic [1:0]  rw_mode;
  logic        load_unsigned;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .ADDR_W(10)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .wr_en_dmem   (wr_en_dmem),
    .rw_mode      (rw_mode),
    .load_unsigned(load_unsigned),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic wr, input logic [1:0] mode, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
    wr_en_dmem    = wr;
    rw_mode       = mode;
    load_unsigned = uns;
    req_addr      = addr;
    req_wdata     = wdata;
  endtask

  // One request; checks latency, ready-low cycles, idle-zero outputs and the response.
  task automatic access(input string tag, input logic wr, input logic [1:0] mode,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input int exp_lat, input logic [31:0] exp_rdata,
                        input logic [31:0] mask, input logic exp_err);
    int lat;
    int low;
    lat = 0;
    low = 0;
    @(negedge clk);
    chk({tag, "/ready_idle"}, 32'(req_ready), 32'd1);
    set_req(wr, mode, uns, addr, wdata);
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (!req_ready) low++;
      if (resp_valid) begin
        lat = i;
        break;
      end
      chk({tag, "/quiet"}, resp_rdata | 32'(resp_err), 32'd0);
    end
    chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "/ready_low"}, 32'(low), 32'(exp_lat));
    chk({tag, "/rdata"}, resp_rdata & mask, exp_rdata);
    chk({tag, "/err"}, 32'(resp_err), 32'(exp_err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] acc_mask;
    logic [8:0] rsp_mask;
    logic [31:0] b2b_data;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    set_req(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    #12;
    chk("reset/ready", 32'(req_ready), 32'd1);
    chk("reset/resp_valid", 32'(resp_valid), 32'd0);
    chk("reset/rdata", resp_rdata, 32'd0);
    chk("reset/err", 32'(resp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    access("sw_010", 1'b1, 2'b00, 1'b0, 32'h010, 32'hDEADBEEF, 5, 32'h0, 32'hFFFFFFFF, 1'b0);
    access("lw_010", 1'b0, 2'b00, 1'b0, 32'h010, 32'h0, 5, 32'hDEADBEEF, 32'hFFFFFFFF, 1'b0);
    access("lb_013", 1'b0, 2'b10, 1'b0, 32'h013, 32'h0, 2, 32'hFFFFFFDE, 32'hFFFFFFFF, 1'b0);

    access("sb_003", 1'b1, 2'b10, 1'b0, 32'h003, 32'h000000F0, 2, 32'h0, 32'hFFFFFFFF, 1'b0);
    access("lb_003", 1'b0, 2'b10, 1'b0, 32'h003, 32'h0, 2, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b0);
    access("lbu_003", 1'b0, 2'b10, 1'b1, 32'h003, 32'h0, 2, 32'h000000F0, 32'hFFFFFFFF, 1'b0);
    // Address bits above ADDR_W are ignored.
    access("lbu_403", 1'b0, 2'b10, 1'b1, 32'h403, 32'h0, 2, 32'h000000F0, 32'hFFFFFFFF, 1'b0);

    access("sh_3fe", 1'b1, 2'b01, 1'b0, 32'h3FE, 32'h00008001, 3, 32'h0, 32'hFFFFFFFF, 1'b0);
    access("lh_3fe", 1'b0, 2'b01, 1'b0, 32'h3FE, 32'h0, 3, 32'hFFFF8001, 32'hFFFFFFFF, 1'b0);
    access("lhu_3fe", 1'b0, 2'b01, 1'b1, 32'h3FE, 32'h0, 3, 32'h00008001, 32'hFFFFFFFF, 1'b0);
    access("lw_3fc", 1'b0, 2'b00, 1'b0, 32'h3FC, 32'h0, 5, 32'h80010000, 32'hFFFF0000, 1'b0);

    access("lw_002_err", 1'b0, 2'b00, 1'b0, 32'h002, 32'h0, 1, 32'h0, 32'hFFFFFFFF, 1'b1);
    access("sh_005_err", 1'b1, 2'b01, 1'b0, 32'h005, 32'hFFFF, 1, 32'h0, 32'hFFFFFFFF, 1'b1);
    access("sh_011_err", 1'b1, 2'b01, 1'b0, 32'h011, 32'hFFFF, 1, 32'h0, 32'hFFFFFFFF, 1'b1);
    access("m11_010_err", 1'b1, 2'b11, 1'b0, 32'h010, 32'h0, 1, 32'h0, 32'hFFFFFFFF, 1'b1);
    access("lw_010_after", 1'b0, 2'b00, 1'b0, 32'h010, 32'h0, 5, 32'hDEADBEEF, 32'hFFFFFFFF,
           1'b0);

    // Reset after two store beats: no response, first two bytes kept.
    @(negedge clk);
    set_req(1'b1, 2'b00, 1'b0, 32'h020, 32'h11223344);
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("abort/no_resp_t1", 32'(resp_valid), 32'd0);
    @(negedge clk);
    chk("abort/no_resp_t2", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort/ready", 32'(req_ready), 32'd1);
    chk("abort/resp_valid", 32'(resp_valid), 32'd0);
    chk("abort/rdata", resp_rdata, 32'd0);
    chk("abort/err", 32'(resp_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    access("lbu_020", 1'b0, 2'b10, 1'b1, 32'h020, 32'h0, 2, 32'h00000044, 32'hFFFFFFFF, 1'b0);
    access("lbu_021", 1'b0, 2'b10, 1'b1, 32'h021, 32'h0, 2, 32'h00000033, 32'hFFFFFFFF, 1'b0);

    // req_valid held high: byte loads accepted every third cycle.
    acc_mask = '0;
    rsp_mask = '0;
    b2b_data = '0;
    @(negedge clk);
    set_req(1'b0, 2'b10, 1'b0, 32'h003, 32'h0);
    req_valid = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) @(negedge clk);
      acc_mask[c] = req_ready;
      rsp_mask[c] = resp_valid;
      if (resp_valid) b2b_data = resp_rdata;
    end
    req_valid = 1'b0;
    chk("b2b/accepts", 32'(acc_mask), 32'h049);
    chk("b2b/responses", 32'(rsp_mask), 32'h124);
    chk("b2b/rdata", b2b_data, 32'hFFFFFFF0);
    @(negedge clk);
    chk("b2b/idle_after", 32'(req_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
